// File: rtl/fft_stream_ctrl.sv
`default_nettype none
// ==========================================================================
// fft_stream_ctrl - valid/ready sequencer around fftmain (two samples/clk).
// Optional FFT_STREAM_CTRL_DRAIN_EN adds i_drain and a zero-flush DRAIN state.
// Rev 1.0
// ==========================================================================
module fft_stream_ctrl #(
  parameter int IWIDTH = 12,
  parameter int OWIDTH = 19,
  parameter int LGN    = 12
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
`ifdef FFT_STREAM_CTRL_DRAIN_EN
  input  logic                i_drain,
`endif
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_first,
  input  logic [2*IWIDTH-1:0] s_left,
  input  logic [2*IWIDTH-1:0] s_right,
  output logic                fft_reset,
  output logic                fft_ce,
  output logic [2*IWIDTH-1:0] fft_left,
  output logic [2*IWIDTH-1:0] fft_right,
  input  logic                fft_sync,
  input  logic [2*OWIDTH-1:0] fft_oleft,
  input  logic [2*OWIDTH-1:0] fft_oright,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [2*OWIDTH-1:0] m_left,
  output logic [2*OWIDTH-1:0] m_right,
  output logic [LGN-1:0]      m_bin,
  output logic                m_last,
  output logic                o_busy,
  output logic                o_err_align
);

`ifdef FFT_STREAM_CTRL_DRAIN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, STREAM = 2'd2, DRAIN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, STREAM = 2'd2} state_t;
`endif

  localparam logic [LGN-1:0] LAST_BIN = {{(LGN-1){1'b1}}, 1'b0};

  state_t           state, state_nxt;
  logic [LGN-2:0]   in_cnt;
  logic [LGN-1:0]   bin_cnt;
  logic             pending;
  logic             in_frame;
  logic             err_align;
  logic             free;
  logic             feed;
  logic             xfer;
  logic             out_take;
  logic             drain_stop;
  logic             hold_out;

  // pending: the FFT outputs moved since the last consumed pair
  assign m_valid   = pending & (fft_sync | in_frame) & ~hold_out;
  assign m_left    = fft_oleft;
  assign m_right   = fft_oright;
  assign m_bin     = fft_sync ? '0 : bin_cnt;
  assign m_last    = (m_bin == LAST_BIN);
  assign out_take  = m_valid & m_ready;
  assign free      = ~m_valid | m_ready;

  assign fft_reset   = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_err_align = err_align;
  assign fft_left    = feed ? s_left  : '0;
  assign fft_right   = feed ? s_right : '0;

`ifdef FFT_STREAM_CTRL_DRAIN_EN
  logic       drain_req;
  logic [3:0] owed;
  logic       frame_in_done;

  // owed counts input frames whose last output bin has not been consumed yet
  assign frame_in_done = xfer & (in_cnt == '1);
  assign drain_stop    = drain_req & (in_cnt == '0);
  assign hold_out      = (state == DRAIN) & (owed == '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      drain_req <= 1'b0;
      owed      <= '0;
    end else begin
      drain_req <= (state == STREAM) ? (drain_req | i_drain) : 1'b0;
      if (state == IDLE)
        owed <= '0;
      else
        owed <= owed + 4'(frame_in_done) - 4'(out_take & m_last);
    end
  end
`else
  assign drain_stop = 1'b0;
  assign hold_out   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    fft_ce    = 1'b0;
    feed      = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = ALIGN;
      end
      ALIGN: begin
        s_ready = 1'b1;
        feed    = 1'b1;
        if (s_valid && s_first) begin
          fft_ce    = 1'b1;
          xfer      = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        feed    = 1'b1;
        s_ready = free & ~drain_stop;
        fft_ce  = s_valid & s_ready;
        xfer    = fft_ce;
`ifdef FFT_STREAM_CTRL_DRAIN_EN
        if (drain_stop) state_nxt = DRAIN;
`endif
      end
`ifdef FFT_STREAM_CTRL_DRAIN_EN
      DRAIN: begin
        fft_ce = free & (owed != '0);
        if (owed == '0) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      in_cnt    <= '0;
      bin_cnt   <= '0;
      pending   <= 1'b0;
      in_frame  <= 1'b0;
      err_align <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        in_cnt   <= '0;
        bin_cnt  <= '0;
        pending  <= 1'b0;
        in_frame <= 1'b0;
      end else begin
        if (xfer) begin
          in_cnt <= in_cnt + 1'b1;
          if (s_first && in_cnt != '0) err_align <= 1'b1;
        end
        if (fft_ce)
          pending <= 1'b1;
        else if (out_take)
          pending <= 1'b0;
        if (out_take) begin
          if (m_last) begin
            in_frame <= 1'b0;
            bin_cnt  <= '0;
          end else begin
            in_frame <= 1'b1;
            bin_cnt  <= m_bin + LGN'(2);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
